sram_stream_reader: RTL and testbench

- Read-side initiator for the single-word SRAM macro's read-only port (a_en/a_re/a_addr → a_rdata/a_rvalid, fixed 2-cycle latency).
- Accepts a strided burst command, issues one read per cycle, and absorbs the fixed latency in a credit-controlled prefetch FIFO.
- Emits words on a valid/ready stream toward the MAC array, with full backpressure.

---
 rtl/sram_stream_reader_if.sv | 42 ++++
 rtl/sram_stream_reader.sv | 141 ++++++++++++++
 tb/tb_sram_stream_reader.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_stream_reader_if.sv
// Bundle between the strided SRAM reader and its neighbours: command port,
// SRAM read port, output word stream and status.
interface sram_stream_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic [ADDR_W-1:0] cmd_stride;

    logic              mem_en;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic              busy;
    logic              done;
    logic              err_rsp;

    modport master (
        input  cmd_valid, cmd_base, cmd_len, cmd_stride,
        input  mem_rdata, mem_rvalid, out_ready,
        output cmd_ready, mem_en, mem_re, mem_addr,
        output out_valid, out_data, out_last, busy, done, err_rsp
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, cmd_stride,
        output mem_rdata, mem_rvalid, out_ready,
        input  cmd_ready, mem_en, mem_re, mem_addr,
        input  out_valid, out_data, out_last, busy, done, err_rsp
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Strided burst reader for the fixed-latency SRAM read port; a credit-limited
// prefetch FIFO absorbs the read latency and feeds a valid/ready word stream.
module sram_stream_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 11,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst,
    sram_stream_reader_if.master bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_check
        $error("FIFO_DEPTH must be at least RD_LAT+1 to sustain one word per cycle");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr, stride_q;
    logic [LEN_W-1:0]  len_q, issue_cnt, pop_cnt;
    logic [CNT_W-1:0]  outstanding, fifo_count;
    logic [CNT_W:0]    in_use;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic              done_q, err_q;
    logic              issue, cmd_ready, fifo_empty, rsp_ok, rsp_bad;
    logic              pop, fifo_wr, fifo_rd, last_word, final_hs;

    // Credits come from registered counters only, so a same-cycle pop never
    // lets an extra read slip in.
    assign in_use     = {1'b0, outstanding} + {1'b0, fifo_count};
    assign fifo_empty = (fifo_count == '0);
    assign rsp_ok     = bus.mem_rvalid && (outstanding != '0);
    assign rsp_bad    = bus.mem_rvalid && (outstanding == '0);

    // Empty FIFO forwards the arriving response straight to the stream.
    assign bus.out_valid = !fifo_empty || rsp_ok;
    assign bus.out_data  = !fifo_empty ? fifo_mem[rd_ptr] : (rsp_ok ? bus.mem_rdata : '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign fifo_rd       = pop && !fifo_empty;
    assign fifo_wr       = rsp_ok && !(pop && fifo_empty);
    assign last_word     = (pop_cnt == len_q - LEN_W'(1));
    assign final_hs      = pop && last_word;
    assign bus.out_last  = bus.out_valid && last_word;

    assign bus.cmd_ready = cmd_ready;
    assign bus.mem_en    = issue;
    assign bus.mem_re    = issue;
    assign bus.mem_addr  = issue ? cur_addr : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.err_rsp   = err_q;

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                if (bus.cmd_valid && bus.cmd_len != '0) state_nxt = ISSUE;
            end
            ISSUE: begin
                issue = (in_use < (CNT_W+1)'(FIFO_DEPTH));
                if (issue && issue_cnt == len_q - LEN_W'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (final_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr    <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            issue_cnt   <= '0;
            pop_cnt     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= (state == IDLE && bus.cmd_valid && bus.cmd_len == '0) ||
                      (state == DRAIN && final_hs);
            if (rsp_bad) err_q <= 1'b1;

            if (state == IDLE && bus.cmd_valid) begin
                cur_addr  <= bus.cmd_base;
                stride_q  <= bus.cmd_stride;
                len_q     <= bus.cmd_len;
                issue_cnt <= '0;
                pop_cnt   <= '0;
            end else begin
                if (issue) begin
                    cur_addr  <= cur_addr + stride_q;
                    issue_cnt <= issue_cnt + LEN_W'(1);
                end
                if (pop) pop_cnt <= pop_cnt + LEN_W'(1);
            end

            case ({issue, rsp_ok})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: ;
            endcase

            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
            if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: the storage array is not reset; the count and pointers alone
    // define which entries are valid.
    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: fixed scenarios plus randomized
// bursts, compared against an address/data model of the strided read.
module tb_sram_stream_reader;
    localparam int ADDR_W = 10, DATA_W = 32, LEN_W = 11, RD_LAT = 2, FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spur = 1'b0;
    always #5 clk = ~clk;

    sram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus();

    sram_stream_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // SRAM macro model: fixed RD_LAT pipeline, not reset.
    logic [DATA_W-1:0] sram [1 << ADDR_W];
    logic [RD_LAT-1:0] pv = '0;
    logic [DATA_W-1:0] pd [RD_LAT];
    always @(posedge clk) begin
        pv    <= {pv[RD_LAT-2:0], bus.mem_en && bus.mem_re};
        pd[0] <= sram[bus.mem_addr];
        for (int i = 1; i < RD_LAT; i++) pd[i] <= pd[i-1];
    end
    assign bus.mem_rvalid = pv[RD_LAT-1] | spur;
    assign bus.mem_rdata  = pd[RD_LAT-1];

    int errors = 0, checks = 0, cyc = 0;
    int iss_n, pop_n, credit_bad, hold_bad, re_bad, acc_cyc;
    bit hold_pending, rdy_rand, busy_seen;
    logic [DATA_W-1:0] held_data;
    logic [ADDR_W-1:0] addr_q[$];
    logic [DATA_W-1:0] data_q[$];
    bit                last_q[$];
    int                en_cyc_q[$], pop_cyc_q[$], done_q[$];

    function automatic logic [ADDR_W-1:0] exp_addr(int base, int stride, int i);
        return ADDR_W'((base + i * stride) % (1 << ADDR_W));
    endfunction

    task automatic clear_mon();
        addr_q.delete(); data_q.delete(); last_q.delete();
        en_cyc_q.delete(); pop_cyc_q.delete(); done_q.delete();
        iss_n = 0; pop_n = 0; credit_bad = 0; hold_bad = 0; re_bad = 0;
        hold_pending = 0; busy_seen = 0;
    endtask

    // Sample one cycle at the falling edge, then move to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        if (bus.mem_en) begin
            if (iss_n - pop_n >= FIFO_DEPTH) credit_bad++;
            if (bus.mem_re !== 1'b1) re_bad++;
            addr_q.push_back(bus.mem_addr);
            en_cyc_q.push_back(cyc);
            iss_n++;
        end
        if (hold_pending && (bus.out_valid !== 1'b1 || bus.out_data !== held_data)) hold_bad++;
        if (bus.out_valid && bus.out_ready) begin
            data_q.push_back(bus.out_data);
            last_q.push_back(bus.out_last);
            pop_cyc_q.push_back(cyc);
            pop_n++;
        end
        hold_pending = bus.out_valid && !bus.out_ready;
        held_data    = bus.out_data;
        if (bus.done) done_q.push_back(cyc);
        if (bus.busy) busy_seen = 1;
        cyc++;
        @(posedge clk);
        #1;
        if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_cmd(input int base, input int len, input int stride);
        bus.cmd_valid  = 1'b1;
        bus.cmd_base   = ADDR_W'(base);
        bus.cmd_len    = LEN_W'(len);
        bus.cmd_stride = ADDR_W'(stride);
        acc_cyc = cyc;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (done_q.size() == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles (want done)", tag, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.cmd_ready, bus.mem_en, bus.mem_re, bus.mem_addr, bus.out_valid, bus.out_data,
             bus.out_last, bus.busy, bus.done, bus.err_rsp} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {bus.cmd_ready, bus.mem_en, bus.mem_re,
                     bus.mem_addr, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done, bus.err_rsp});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy);
        end
    endtask

    task automatic test_basic();
        clear_mon();
        rdy_rand = 0;
        bus.out_ready = 1'b1;
        send_cmd(16, 4, 1);
        wait_done(40, "basic");
        checks++;
        if (addr_q.size() != 4 || data_q.size() != 4) begin
            errors++;
            $display("FAIL basic_count: issues=%0d words=%0d want 4 4", addr_q.size(), data_q.size());
        end
        for (int i = 0; i < 4 && i < addr_q.size() && i < data_q.size(); i++) begin
            checks++;
            if (addr_q[i] !== ADDR_W'(16 + i) || en_cyc_q[i] != acc_cyc + 1 + i) begin
                errors++;
                $display("FAIL basic_addr[%0d]: got %h@%0d want %h@%0d", i, addr_q[i], en_cyc_q[i],
                         16 + i, acc_cyc + 1 + i);
            end
            checks++;
            if (data_q[i] !== 32'h110 + 32'h11 * i || last_q[i] !== (i == 3) ||
                pop_cyc_q[i] != acc_cyc + 1 + RD_LAT + i) begin
                errors++;
                $display("FAIL basic_data[%0d]: got %h last=%b @%0d want %h last=%b @%0d", i, data_q[i],
                         last_q[i], pop_cyc_q[i], 32'h110 + 32'h11 * i, i == 3, acc_cyc + 1 + RD_LAT + i);
            end
        end
        checks++;
        if (done_q.size() != 1 || pop_cyc_q.size() != 4 || done_q[0] != pop_cyc_q[3] + 1 || re_bad != 0) begin
            errors++;
            $display("FAIL basic_done: done pulses=%0d re_bad=%0d want one pulse after last word, re_bad 0",
                     done_q.size(), re_bad);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] ea [3];
        ea[0] = 10'h3FE; ea[1] = 10'h001; ea[2] = 10'h004;
        clear_mon();
        bus.out_ready = 1'b1;
        send_cmd(10'h3FE, 3, 3);
        wait_done(40, "wrap");
        checks++;
        if (addr_q.size() != 3 || data_q.size() != 3) begin
            errors++;
            $display("FAIL wrap_count: issues=%0d words=%0d want 3 3", addr_q.size(), data_q.size());
        end
        for (int i = 0; i < 3 && i < addr_q.size() && i < data_q.size(); i++) begin
            checks++;
            if (addr_q[i] !== ea[i] || data_q[i] !== sram[ea[i]] || last_q[i] !== (i == 2)) begin
                errors++;
                $display("FAIL wrap[%0d]: got addr %h data %h last %b want %h %h %b", i, addr_q[i],
                         data_q[i], last_q[i], ea[i], sram[ea[i]], i == 2);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_mon();
        bus.out_ready = 1'b0;
        send_cmd(12'h100, 8, 1);
        repeat (9) step();
        checks++;
        if (addr_q.size() != FIFO_DEPTH || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall_issues: got %0d issues out_valid=%b want %0d 1", addr_q.size(),
                     bus.out_valid, FIFO_DEPTH);
        end
        bus.out_ready = 1'b1;
        wait_done(60, "bp");
        checks++;
        if (data_q.size() != 8 || credit_bad != 0 || hold_bad != 0) begin
            errors++;
            $display("FAIL bp_flow: words=%0d credit_bad=%0d hold_bad=%0d want 8 0 0", data_q.size(),
                     credit_bad, hold_bad);
        end
        for (int i = 0; i < 8 && i < data_q.size(); i++) begin
            checks++;
            if (data_q[i] !== sram[exp_addr(12'h100, 1, i)] || last_q[i] !== (i == 7)) begin
                errors++;
                $display("FAIL bp_data[%0d]: got %h last %b want %h %b", i, data_q[i], last_q[i],
                         sram[exp_addr(12'h100, 1, i)], i == 7);
            end
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        send_cmd(5, 0, 1);
        repeat (4) step();
        checks++;
        if (addr_q.size() != 0 || done_q.size() != 1 || busy_seen) begin
            errors++;
            $display("FAIL zero_len: issues=%0d done pulses=%0d busy_seen=%b want 0 1 0", addr_q.size(),
                     done_q.size(), busy_seen);
        end else begin
            checks++;
            if (done_q[0] != acc_cyc + 1) begin
                errors++;
                $display("FAIL zero_len_done_cycle: got %0d want %0d", done_q[0], acc_cyc + 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_mon();
        bus.out_ready = 1'b1;
        send_cmd(12'h200, 16, 1);
        while (pop_n < 5 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (pop_n < 5) begin
            errors++;
            $display("FAIL rstmid_timeout: got %0d words want 5", pop_n);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.cmd_ready, bus.mem_en, bus.mem_re, bus.mem_addr, bus.out_valid, bus.out_data,
             bus.out_last, bus.busy, bus.done, bus.err_rsp} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %h want 0", {bus.cmd_ready, bus.mem_en, bus.mem_re,
                     bus.mem_addr, bus.out_valid, bus.out_data, bus.out_last, bus.busy, bus.done, bus.err_rsp});
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        repeat (5) step();
        checks++;
        if (done_q.size() != 0 || addr_q.size() != 0 || bus.err_rsp !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: done=%0d issues=%0d err_rsp=%b want 0 0 0", done_q.size(),
                     addr_q.size(), bus.err_rsp);
        end
        clear_mon();
        send_cmd(12'h040, 2, 2);
        wait_done(40, "rstmid_new");
        checks++;
        if (data_q.size() != 2 || data_q[0] !== sram[10'h040] || data_q[1] !== sram[10'h042] ||
            last_q[1] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_new_burst: got %0d words want 2 words %h %h", data_q.size(),
                     sram[10'h040], sram[10'h042]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = $urandom;
        rdy_rand = 1;
        for (int b = 0; b < 6; b++) begin
            int base   = $urandom_range(0, (1 << ADDR_W) - 1);
            int stride = $urandom_range(0, (1 << ADDR_W) - 1);
            int len    = $urandom_range(1, 24);
            clear_mon();
            send_cmd(base, len, stride);
            wait_done(400, "rand");
            checks++;
            if (data_q.size() != len || addr_q.size() != len || credit_bad != 0 || hold_bad != 0) begin
                errors++;
                $display("FAIL rand%0d_flow: words=%0d issues=%0d credit_bad=%0d hold_bad=%0d want %0d %0d 0 0",
                         b, data_q.size(), addr_q.size(), credit_bad, hold_bad, len, len);
            end
            for (int i = 0; i < len && i < data_q.size() && i < addr_q.size(); i++) begin
                checks++;
                if (addr_q[i] !== exp_addr(base, stride, i) || data_q[i] !== sram[exp_addr(base, stride, i)] ||
                    last_q[i] !== (i == len - 1)) begin
                    errors++;
                    $display("FAIL rand%0d[%0d]: got %h/%h/%b want %h/%h/%b", b, i, addr_q[i], data_q[i],
                             last_q[i], exp_addr(base, stride, i), sram[exp_addr(base, stride, i)], i == len - 1);
                end
            end
        end
        rdy_rand = 0;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.err_rsp !== 1'b0) begin
            errors++;
            $display("FAIL rand_err_rsp: got %b want 0", bus.err_rsp);
        end
    endtask

    task automatic test_spurious();
        spur = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.err_rsp !== 1'b0) begin
            errors++;
            $display("FAIL spur_same_cycle: out_valid=%b err_rsp=%b want 0 0", bus.out_valid, bus.err_rsp);
        end
        @(posedge clk);
        #1;
        spur = 1'b0;
        checks++;
        if (bus.err_rsp !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL spur_flag: err_rsp=%b out_valid=%b want 1 0", bus.err_rsp, bus.out_valid);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.err_rsp !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL spur_sticky: err_rsp=%b out_valid=%b busy=%b want 1 0 0", bus.err_rsp,
                     bus.out_valid, bus.busy);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.err_rsp !== 1'b0) begin
            errors++;
            $display("FAIL spur_clear: err_rsp=%b want 0", bus.err_rsp);
        end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_base   = '0;
        bus.cmd_len    = '0;
        bus.cmd_stride = '0;
        bus.out_ready  = 1'b0;
        rdy_rand       = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = DATA_W'(i * 32'h11);
        clear_mon();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_random();
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
